// File: rtl/iob_dma_mc_sched.sv
// Multi-channel DMA burst scheduler. Each channel's descriptor is split into bursts that are at most
// MAX_BURST beats and never cross a 4 KB boundary. The bursts are arbitrated round-robin onto one command port.
module iob_dma_mc_sched #(
    parameter int  N_CH      = 2,
    parameter int  ADDR_W    = 32,
    parameter int  DATA_W    = 32,
    parameter int  LEN_W     = 8,
    parameter int  MAX_BURST = 16,
    parameter int  SIZE_W    = 24,
    parameter int  LVL_W     = 9,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk_i,
    input  logic                     cke_i,
    input  logic                     arst_n_i,
    input  logic [N_CH-1:0]          cfg_valid_i,
    output logic [N_CH-1:0]          cfg_ready_o,
    input  logic [N_CH*ADDR_W-1:0]   cfg_addr_i,
    input  logic [N_CH*SIZE_W-1:0]   cfg_len_i,
    input  logic [N_CH-1:0]          cfg_dir_i,
    input  logic [N_CH*LVL_W-1:0]    ch_level_i,
    output logic                     cmd_valid_o,
    input  logic                     cmd_ready_i,
    output logic [CH_W-1:0]          cmd_ch_o,
    output logic                     cmd_dir_o,
    output logic [ADDR_W-1:0]        cmd_addr_o,
    output logic [LEN_W-1:0]         cmd_len_o,
    input  logic                     done_valid_i,
    input  logic [CH_W-1:0]          done_ch_i,
    input  logic                     done_err_i,
    output logic [N_CH-1:0]          busy_o,
    output logic [N_CH-1:0]          done_o,
    output logic [N_CH-1:0]          err_o
);
    localparam int BYTES = DATA_W / 8;
    localparam int B_LOG = $clog2(BYTES);
    localparam int LB_W  = (SIZE_W + 1 > 13) ? SIZE_W + 1 : 13;
    localparam int CMP_W = (LB_W > LVL_W) ? LB_W : LVL_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    logic [1:0]        st_q   [N_CH];
    logic [1:0]        st_d   [N_CH];
    logic [ADDR_W-1:0] addr_q [N_CH];
    logic [ADDR_W-1:0] addr_d [N_CH];
    logic [SIZE_W-1:0] rem_q  [N_CH];
    logic [SIZE_W-1:0] rem_d  [N_CH];
    logic [N_CH-1:0]   dir_q, dir_d;
    logic [N_CH-1:0]   err_q, err_d;
    logic [LB_W-1:0]   len_b  [N_CH];
    logic [N_CH-1:0]   elig;

    logic              cmd_valid_q, cmd_valid_d;
    logic [CH_W-1:0]   cmd_ch_q, cmd_ch_d;
    logic              cmd_dir_q, cmd_dir_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [LEN_W-1:0]  cmd_len_q, cmd_len_d;
    logic [CH_W-1:0]   rr_q, rr_d;

    logic [CH_W:0]     pick;
    logic [CH_W-1:0]   gnt_ch;
    logic              can_load;
    logic              grant;

    // Current burst length: limited by remaining words, MAX_BURST and the distance to the next 4 KB page.
    function automatic logic [LB_W-1:0] burst_len(input logic [11:0] addr_lo, input logic [SIZE_W-1:0] rem);
        logic [LB_W-1:0] len;
        logic [LB_W-1:0] to_4k;
        to_4k = LB_W'((13'h1000 - {1'b0, addr_lo}) >> B_LOG);
        len   = LB_W'(rem);
        if (LB_W'(MAX_BURST) < len) len = LB_W'(MAX_BURST);
        if (to_4k < len) len = to_4k;
        return len;
    endfunction

    function automatic logic [CH_W:0] rr_pick(input logic [N_CH-1:0] req, input logic [CH_W-1:0] last);
        logic [CH_W:0] res;
        int            idx;
        res = '0;
        for (int i = 1; i <= N_CH; i++) begin
            idx = int'(last) + i;
            if (idx >= N_CH) idx = idx - N_CH;
            if (!res[CH_W] && req[idx]) res = {1'b1, CH_W'(idx)};
        end
        return res;
    endfunction

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            len_b[c] = burst_len(addr_q[c][11:0], rem_q[c]);
            elig[c]  = (st_q[c] == ST_ISSUE) &&
                       (CMP_W'(ch_level_i[c*LVL_W +: LVL_W]) >= CMP_W'(len_b[c]));
        end
    end

    assign pick     = rr_pick(elig, rr_q);
    assign gnt_ch   = pick[CH_W-1:0];
    assign can_load = !cmd_valid_q || cmd_ready_i;
    assign grant    = cke_i && pick[CH_W] && can_load;

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            st_d[c]   = st_q[c];
            addr_d[c] = addr_q[c];
            rem_d[c]  = rem_q[c];
            dir_d[c]  = dir_q[c];
            err_d[c]  = err_q[c];
            if (cke_i) begin
                case (st_q[c])
                    ST_IDLE: begin
                        if (cfg_valid_i[c]) begin
                            addr_d[c] = cfg_addr_i[c*ADDR_W +: ADDR_W] & ~ADDR_W'(BYTES - 1);
                            rem_d[c]  = cfg_len_i[c*SIZE_W +: SIZE_W];
                            dir_d[c]  = cfg_dir_i[c];
                            err_d[c]  = 1'b0;
                            st_d[c]   = (cfg_len_i[c*SIZE_W +: SIZE_W] == '0) ? ST_FIN : ST_ISSUE;
                        end
                    end
                    ST_ISSUE: begin
                        if (grant && (gnt_ch == CH_W'(c))) st_d[c] = ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (done_valid_i && (done_ch_i == CH_W'(c))) begin
                            addr_d[c] = addr_q[c] + (ADDR_W'(len_b[c]) << B_LOG);
                            rem_d[c]  = rem_q[c] - SIZE_W'(len_b[c]);
                            err_d[c]  = err_q[c] | done_err_i;
                            st_d[c]   = ((rem_q[c] == SIZE_W'(len_b[c])) || done_err_i) ? ST_FIN : ST_ISSUE;
                        end
                    end
                    default: st_d[c] = ST_IDLE;
                endcase
            end
        end
    end

    // The command register may drop its accepted command and load the next grant in the same cycle.
    always_comb begin
        cmd_valid_d = cmd_valid_q;
        cmd_ch_d    = cmd_ch_q;
        cmd_dir_d   = cmd_dir_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_len_d   = cmd_len_q;
        rr_d        = rr_q;
        if (cke_i) begin
            if (cmd_valid_q && cmd_ready_i) cmd_valid_d = 1'b0;
            if (grant) begin
                cmd_valid_d = 1'b1;
                cmd_ch_d    = gnt_ch;
                cmd_dir_d   = dir_q[gnt_ch];
                cmd_addr_d  = addr_q[gnt_ch];
                cmd_len_d   = LEN_W'(len_b[gnt_ch] - LB_W'(1));
                rr_d        = gnt_ch;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            for (int c = 0; c < N_CH; c++) begin
                st_q[c]   <= ST_IDLE;
                addr_q[c] <= '0;
                rem_q[c]  <= '0;
            end
            dir_q       <= '0;
            err_q       <= '0;
            cmd_valid_q <= 1'b0;
            cmd_ch_q    <= '0;
            cmd_dir_q   <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_len_q   <= '0;
            rr_q        <= CH_W'(N_CH - 1);
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                st_q[c]   <= st_d[c];
                addr_q[c] <= addr_d[c];
                rem_q[c]  <= rem_d[c];
            end
            dir_q       <= dir_d;
            err_q       <= err_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_ch_q    <= cmd_ch_d;
            cmd_dir_q   <= cmd_dir_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_len_q   <= cmd_len_d;
            rr_q        <= rr_d;
        end
    end

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            cfg_ready_o[c] = cke_i && (st_q[c] == ST_IDLE);
            busy_o[c]      = (st_q[c] != ST_IDLE);
            done_o[c]      = cke_i && (st_q[c] == ST_FIN);
            err_o[c]       = err_q[c];
        end
    end

    assign cmd_valid_o = cmd_valid_q && cke_i;
    assign cmd_ch_o    = cmd_ch_q;
    assign cmd_dir_o   = cmd_dir_q;
    assign cmd_addr_o  = cmd_addr_q;
    assign cmd_len_o   = cmd_len_q;

endmodule
